// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single DataMemory port between the decode stage (operand reads)
// and the writeback stage (loads/stores). Each access is sequenced through a
// three-state FSM. The memory strobes are held for MEM_LAT cycles. Read data
// is then captured and a one-cycle ack goes back to the winning requester.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin arbitration on ties (1-bit last-grant pointer)
//   undefined : fixed priority, writeback over decode
//
// Ports
//   clk, reset            system clock (rising edge), async active-low reset
//   d_req/d_addr/d_mode   decode read request; d_rdata/d_ack/d_stall back
//   w_req/w_wr/w_addr/
//   w_mode/w_wdata        writeback load/store request; w_rdata/w_ack back
//   rd_mem/wr_mem/address/
//   mode_mem/write_data_mem
//                         memory-side strobes, address, mode and store data
//   mem_data              memory read data
//   gnt                   current owner: 01=decode, 10=writeback, 00=none
//
// state  | meaning
// IDLE   | no access in flight; arbitrate on any request
// ACCESS | strobes held, latency counter running down to zero
// DONE   | ack pulse to the winner; release grant
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_mode,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  input  logic              w_req,
  input  logic              w_wr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              w_mode,
  input  logic [DATA_W-1:0] w_wdata,
  output logic [DATA_W-1:0] w_rdata,
  output logic              w_ack,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [ADDR_W-1:0] address,
  output logic              mode_mem,
  output logic [DATA_W-1:0] write_data_mem,
  input  logic [DATA_W-1:0] mem_data,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_win_wb;

`ifdef ARB_RR_EN
  // 1 = writeback was granted last; on a tie the other port wins
  logic r_last_wb;
  assign w_win_wb = w_req & (~d_req | ~r_last_wb);
`else
  assign w_win_wb = w_req;
`endif

  assign d_stall = d_req & ~d_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      rd_mem         <= 1'b0;
      wr_mem         <= 1'b0;
      address        <= '0;
      mode_mem       <= 1'b0;
      write_data_mem <= '0;
      d_rdata        <= '0;
      w_rdata        <= '0;
      d_ack          <= 1'b0;
      w_ack          <= 1'b0;
      gnt            <= 2'b00;
`ifdef ARB_RR_EN
      r_last_wb      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req || w_req) begin
            address  <= w_win_wb ? w_addr : d_addr;
            mode_mem <= w_win_wb ? w_mode : d_mode;
            // decode never stores, so write data is only refreshed for writeback
            if (w_win_wb) write_data_mem <= w_wdata;
            rd_mem   <= ~w_win_wb | ~w_wr;
            wr_mem   <= w_win_wb & w_wr;
            gnt      <= w_win_wb ? 2'b10 : 2'b01;
            r_cnt    <= LAT_M1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (rd_mem) begin
              if (gnt[1]) w_rdata <= mem_data;
              else        d_rdata <= mem_data;
            end
            rd_mem  <= 1'b0;
            wr_mem  <= 1'b0;
            if (gnt[1]) w_ack <= 1'b1;
            else        d_ack <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          d_ack     <= 1'b0;
          w_ack     <= 1'b0;
          gnt       <= 2'b00;
`ifdef ARB_RR_EN
          r_last_wb <= gnt[1];
`endif
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT2 = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main instance (MEM_LAT = 1)
  logic        d_req, d_mode, w_req, w_wr, w_mode;
  logic [15:0] d_addr, w_addr, w_wdata, mem_data;
  logic [15:0] d_rdata, w_rdata, address, write_data_mem;
  logic        d_ack, d_stall, w_ack, rd_mem, wr_mem, mode_mem;
  logic [1:0]  gnt;

  // second instance (MEM_LAT = 3)
  logic        d_req2, d_mode2, w_req2, w_wr2, w_mode2;
  logic [15:0] d_addr2, w_addr2, w_wdata2, mem_data2;
  logic [15:0] d_rdata2, w_rdata2, address2, write_data_mem2;
  logic        d_ack2, d_stall2, w_ack2, rd_mem2, wr_mem2, mode_mem2;
  logic [1:0]  gnt2;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_mode(d_mode), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_stall(d_stall),
    .w_req(w_req), .w_wr(w_wr), .w_addr(w_addr), .w_mode(w_mode),
    .w_wdata(w_wdata), .w_rdata(w_rdata), .w_ack(w_ack),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .address(address), .mode_mem(mode_mem),
    .write_data_mem(write_data_mem), .mem_data(mem_data), .gnt(gnt));

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT2)) dut2 (
    .clk(clk), .reset(reset),
    .d_req(d_req2), .d_addr(d_addr2), .d_mode(d_mode2), .d_rdata(d_rdata2),
    .d_ack(d_ack2), .d_stall(d_stall2),
    .w_req(w_req2), .w_wr(w_wr2), .w_addr(w_addr2), .w_mode(w_mode2),
    .w_wdata(w_wdata2), .w_rdata(w_rdata2), .w_ack(w_ack2),
    .rd_mem(rd_mem2), .wr_mem(wr_mem2), .address(address2), .mode_mem(mode_mem2),
    .write_data_mem(write_data_mem2), .mem_data(mem_data2), .gnt(gnt2));

  // contents of a location that has never been written
  function automatic logic [15:0] dflt(input logic [7:0] a);
    return 16'hBEEF ^ {a, a} ^ 16'h1010;
  endfunction

  // memory behind the main instance (cleared by reset)
  logic [15:0]  mem [0:255];
  logic [255:0] mem_valid;
  assign mem_data = mem_valid[address[7:0]] ? mem[address[7:0]] : dflt(address[7:0]);
  always @(posedge clk or negedge reset) begin
    if (!reset) mem_valid <= '0;
    else if (wr_mem) begin
      mem[address[7:0]]       <= write_data_mem;
      mem_valid[address[7:0]] <= 1'b1;
    end
  end

  // reference memory kept by the model
  logic [15:0]  model_mem [0:255];
  logic [255:0] model_valid;
  bit           exp_last_wb;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_valid[a[7:0]] ? model_mem[a[7:0]] : dflt(a[7:0]);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    d_req = 0; d_addr = 0; d_mode = 0;
    w_req = 0; w_wr = 0; w_addr = 0; w_mode = 0; w_wdata = 0;
    d_req2 = 0; d_addr2 = 0; d_mode2 = 0;
    w_req2 = 0; w_wr2 = 0; w_addr2 = 0; w_mode2 = 0; w_wdata2 = 0;
    mem_data2 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    d_req = 0; w_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_valid = '0;
    exp_last_wb = 1'b0;
  endtask

  typedef struct packed {
    logic        is_wb;
    logic        wr;
    logic        mode;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  e_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_d_rdata;
    logic [15:0] e_w_rdata;
  } vec_t;

  vec_t tv [10];

  task automatic run_access(input vec_t v, input int idx);
    int ack_k, strobe_cnt;
    string t;
    t = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    if (v.is_wb) begin
      w_req = 1; w_wr = v.wr; w_addr = v.addr; w_mode = v.mode; w_wdata = v.wdata;
    end else begin
      d_req = 1; d_addr = v.addr; d_mode = v.mode;
    end
    @(posedge clk); #1;
    chk({t, "_gnt"}, gnt, v.e_gnt);
    chk({t, "_strobes"}, {rd_mem, wr_mem}, {v.e_rd, v.e_wr});
    chk({t, "_addr_mode"}, {address, mode_mem}, {v.addr, v.mode});
    if (v.wr) chk({t, "_wdata"}, write_data_mem, v.wdata);
    if (!v.is_wb) chk({t, "_stall_pending"}, d_stall, 1'b1);
    strobe_cnt = 0;
    ack_k = 0;
    for (int k = 1; k <= 20 && ack_k == 0; k++) begin
      if (rd_mem | wr_mem) strobe_cnt++;
      @(posedge clk); #1;
      if (d_ack | w_ack) ack_k = k;
    end
    chk({t, "_ack_latency"}, ack_k, LAT);
    chk({t, "_strobe_cycles"}, strobe_cnt, LAT);
    chk({t, "_ack_port"}, {w_ack, d_ack}, v.is_wb ? 2'b10 : 2'b01);
    chk({t, "_strobes_off"}, {rd_mem, wr_mem}, 2'b00);
    chk({t, "_rdata"}, {d_rdata, w_rdata}, {v.e_d_rdata, v.e_w_rdata});
    if (!v.is_wb) chk({t, "_stall_at_ack"}, d_stall, 1'b0);
    d_req = 0; w_req = 0;
    @(posedge clk); #1;
    chk({t, "_release"}, {d_ack, w_ack, gnt}, 4'b0000);
    exp_last_wb = v.is_wb;
  endtask

  initial begin
    int tw, td, n, ack_k, cnt;
    bit exp_wb;

    idle_inputs();
    tv[0] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2'b01, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
    tv[1] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 2'b10, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    tv[2] = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 2'b10, 1'b1, 1'b0, 16'hBEEF, 16'h1234};
    tv[3] = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h1234, 16'h1234};
    tv[4] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'hCAFE, 2'b10, 1'b0, 1'b1, 16'h1234, 16'h1234};
    tv[5] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2'b01, 1'b1, 1'b0, 16'hCAFE, 16'h1234};
    tv[6] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2'b10, 1'b1, 1'b0, 16'hCAFE, 16'hCAFE};
    tv[7] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 2'b10, 1'b0, 1'b1, 16'hCAFE, 16'hCAFE};
    tv[8] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 2'b10, 1'b1, 1'b0, 16'hCAFE, 16'h0001};
    tv[9] = '{1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h8FDE, 16'h0001};

    do_reset();
    chk("reset_state", {rd_mem, wr_mem, address, d_rdata, w_rdata, d_ack, w_ack, gnt}, 0);

    // reset in the middle of a store
    @(posedge clk); #1;
    w_req = 1; w_wr = 1; w_addr = 16'h0004; w_wdata = 16'h1234; w_mode = 1;
    @(posedge clk); #1;
    chk("t1_wr_mem_before_reset", {wr_mem, gnt}, 3'b110);
    #2 reset = 1'b0;
    #1;
    chk("t1_outputs_zero_async",
        {rd_mem, wr_mem, address, mode_mem, write_data_mem, d_rdata, w_rdata, d_ack, w_ack, gnt}, 0);
    w_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_valid = '0;
    exp_last_wb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t1_no_ack_after_reset", {d_ack, w_ack, gnt, wr_mem, rd_mem}, 0);
    end

    // simultaneous requests
    do_reset();
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'h0020; d_mode = 0;
    w_req = 1; w_wr = 0; w_addr = 16'h0030; w_mode = 1;
    @(posedge clk); #1;
    chk("t4_first_gnt", gnt, 2'b10);
    chk("t4_stall_losing", d_stall, 1'b1);
    tw = -100; td = -100;
    for (int k = 1; k <= 30 && td < 0; k++) begin
      if (w_ack) begin
        tw = k - 1;
        chk("t4_w_rdata", w_rdata, dflt(8'h30));
        w_req = 0;
      end
      if (k - 1 == tw + 2) chk("t4_second_gnt", gnt, 2'b01);
      if (d_ack) begin
        td = k - 1;
        chk("t4_d_rdata", d_rdata, dflt(8'h20));
        d_req = 0;
      end
      @(posedge clk); #1;
    end
    chk("t4_ack_order", (tw >= 0 && td > tw), 1'b1);
    chk("t4_ack_spacing", td - tw, LAT + 2);
    exp_last_wb = 1'b0;

    // single accesses from the table
    do_reset();
    for (int i = 0; i < 10; i++) run_access(tv[i], i);

    // decode drops its request mid-access; ack still pulses
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'h0004; d_mode = 0;
    @(posedge clk); #1;
    chk("drop_gnt", gnt, 2'b01);
    d_req = 0;
    #1 chk("drop_stall_low", d_stall, 1'b0);
    @(posedge clk); #1;
    chk("drop_ack_still", d_ack, 1'b1);
    chk("drop_rdata", d_rdata, 16'h1234);
    @(posedge clk); #1;
    chk("drop_release", {d_ack, gnt}, 3'b000);
    exp_last_wb = 1'b0;

    // both requesters held continuously for 8 accesses
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'h0040; d_mode = 0;
    w_req = 1; w_wr = 0; w_addr = 16'h0050; w_mode = 0;
    n = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      @(posedge clk); #1;
      if (d_ack | w_ack) begin
`ifdef ARB_RR_EN
        exp_wb = !exp_last_wb;
`else
        exp_wb = 1'b1;
`endif
        chk($sformatf("t5_winner_%0d", n), {w_ack, d_ack}, exp_wb ? 2'b10 : 2'b01);
        if (w_ack) chk("t5_dstall_while_losing", d_stall, 1'b1);
        exp_last_wb = exp_wb;
        n++;
      end
    end
    chk("t5_access_count", n, 8);
    d_req = 0; w_req = 0;
    repeat (3) @(posedge clk);

    // MEM_LAT = 3 load on the second instance
    @(posedge clk); #1;
    w_req2 = 1; w_wr2 = 0; w_addr2 = 16'h00FF; w_mode2 = 0; mem_data2 = 16'h0F00;
    @(posedge clk); #1;
    chk("t6_grant", {gnt2, rd_mem2, wr_mem2, address2}, {2'b10, 1'b1, 1'b0, 16'h00FF});
    cnt = 0; ack_k = 0;
    for (int k = 1; k <= 20 && ack_k == 0; k++) begin
      if (rd_mem2) cnt++;
      mem_data2 = 16'h1000 | 16'(k);
      @(posedge clk); #1;
      if (w_ack2) ack_k = k;
    end
    chk("t6_rd_cycles", cnt, LAT2);
    chk("t6_ack_latency", ack_k, LAT2);
    chk("t6_rd_off_at_ack", rd_mem2, 1'b0);
    chk("t6_w_rdata_last_sample", w_rdata2, 16'h1003);
    w_req2 = 0;
    @(posedge clk); #1;
    chk("t6_ack_one_cycle", {w_ack2, gnt2}, 3'b000);

    // randomized traffic against the transaction-level model
    do_reset();
    begin
      int g = -100, free_e = 0;
      bit own_wb = 0, own_rd = 0, ack_now;
      logic [15:0] exp_rd = 0, exp_addr = 0, exp_wd = 0, last_d = 0, last_w = 0;
      logic exp_mode = 0;
      logic [1:0] eg;
      for (int c = 0; c < 800; c++) begin
        @(posedge clk); #1;
        if (c >= free_e && (d_req || w_req)) begin
`ifdef ARB_RR_EN
          own_wb = w_req && (!d_req || !exp_last_wb);
`else
          own_wb = w_req;
`endif
          g = c;
          free_e = c + LAT + 2;
          own_rd = !own_wb || !w_wr;
          exp_addr = own_wb ? w_addr : d_addr;
          exp_mode = own_wb ? w_mode : d_mode;
          exp_wd = w_wdata;
          if (own_rd) exp_rd = model_rd(exp_addr);
          else begin
            model_mem[w_addr[7:0]] = w_wdata;
            model_valid[w_addr[7:0]] = 1'b1;
          end
          exp_last_wb = own_wb;
        end
        ack_now = (c == g + LAT);
        if (ack_now && own_rd) begin
          if (own_wb) last_w = exp_rd;
          else        last_d = exp_rd;
        end
        eg = (c >= g && c <= g + LAT) ? (own_wb ? 2'b10 : 2'b01) : 2'b00;
        chk("rnd_gnt", gnt, eg);
        chk("rnd_strobes", {rd_mem, wr_mem},
            {(c >= g && c < g + LAT && own_rd), (c >= g && c < g + LAT && !own_rd)});
        if (c >= g && c < g + LAT) begin
          chk("rnd_addr_mode", {address, mode_mem}, {exp_addr, exp_mode});
          if (!own_rd) chk("rnd_wdata", write_data_mem, exp_wd);
        end
        chk("rnd_acks", {w_ack, d_ack}, {ack_now && own_wb, ack_now && !own_wb});
        chk("rnd_rdata", {d_rdata, w_rdata}, {last_d, last_w});
        chk("rnd_stall", d_stall, d_req && !(ack_now && !own_wb));
        if (ack_now) begin
          if (own_wb) w_req = 0;
          else        d_req = 0;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1;
          d_addr = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 3)) << 12);
          d_mode = 1'($urandom_range(0, 1));
        end
        if (!w_req && $urandom_range(0, 2) == 0) begin
          w_req = 1;
          w_wr = 1'($urandom_range(0, 1));
          w_addr = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 3)) << 12);
          w_mode = 1'($urandom_range(0, 1));
          w_wdata = 16'($urandom);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
